// File: rtl/phase_accumulator.sv
// Four-voice NCO phase generator: a shared sample-rate timer advances four 24-bit
// phase accumulators once per sample period and flags each update with a one-cycle pulse.
module phase_accumulator #(
  parameter int unsigned SAMPLE_PERIOD = 2841
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        fcw_wr_en,
  input  logic [1:0]  fcw_wr_addr,
  input  logic [23:0] fcw_wr_data,
  input  logic [3:0]  phase_clr,
  output logic [23:0] phase_1,
  output logic [23:0] phase_2,
  output logic [23:0] phase_3,
  output logic [23:0] phase_4,
  output logic        out_valid
);

  localparam int unsigned NUM_VOICES = 4;
  localparam int unsigned PHASE_W    = 24;
  localparam int unsigned CNT_W      = $clog2(SAMPLE_PERIOD);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLE_PERIOD - 1);

  // The downstream square-wave stage needs 7 cycles to drain between samples.
  generate
    if (SAMPLE_PERIOD < 8 || SAMPLE_PERIOD > 65535) begin : g_bad_period
      $error("phase_accumulator: SAMPLE_PERIOD must be within 8..65535");
    end
  endgenerate

  logic [CNT_W-1:0]   cnt_q;
  logic [CNT_W-1:0]   cnt_d;
  logic               tick;
  logic [PHASE_W-1:0] fcw_q      [NUM_VOICES];
  logic [PHASE_W-1:0] fcw_d      [NUM_VOICES];
  logic [PHASE_W-1:0] phase_q    [NUM_VOICES];
  logic [PHASE_W-1:0] phase_d    [NUM_VOICES];
  logic [NUM_VOICES-1:0] clr_pend_q;
  logic [NUM_VOICES-1:0] clr_pend_d;
  logic [NUM_VOICES-1:0] clear_now;
  logic               out_valid_q;

  assign tick = enable && (cnt_q == CNT_LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (enable) begin
      cnt_d = tick ? '0 : cnt_q + 1'b1;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_VOICES; gi++) begin : g_voice
      assign fcw_d[gi] = (fcw_wr_en && fcw_wr_addr == 2'(gi)) ? fcw_wr_data : fcw_q[gi];

      // A clear raised on the tick cycle itself is honoured without becoming sticky.
      assign clear_now[gi]  = clr_pend_q[gi] | phase_clr[gi];
      assign clr_pend_d[gi] = tick ? 1'b0 : clear_now[gi];

      // fcw_q (not fcw_d) so a write landing on the tick edge waits for the next sample.
      assign phase_d[gi] = !tick         ? phase_q[gi] :
                           clear_now[gi] ? '0          :
                                           phase_q[gi] + fcw_q[gi];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= '0;
      clr_pend_q  <= '0;
      out_valid_q <= 1'b0;
      for (int i = 0; i < NUM_VOICES; i++) begin
        fcw_q[i]   <= '0;
        phase_q[i] <= '0;
      end
    end else begin
      cnt_q       <= cnt_d;
      clr_pend_q  <= clr_pend_d;
      out_valid_q <= tick;
      for (int i = 0; i < NUM_VOICES; i++) begin
        fcw_q[i]   <= fcw_d[i];
        phase_q[i] <= phase_d[i];
      end
    end
  end

  assign phase_1   = phase_q[0];
  assign phase_2   = phase_q[1];
  assign phase_3   = phase_q[2];
  assign phase_4   = phase_q[3];
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_phase_accumulator.sv
// Directed bench for phase_accumulator with SAMPLE_PERIOD=16: tick timing, accumulation,
// write-on-tick, clears, enable gating and mid-run reset.
module tb_phase_accumulator;

  localparam int unsigned SP = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        fcw_wr_en;
  logic [1:0]  fcw_wr_addr;
  logic [23:0] fcw_wr_data;
  logic [3:0]  phase_clr;
  logic [23:0] phase_1, phase_2, phase_3, phase_4;
  logic        out_valid;

  int total = 0;
  int bad   = 0;
  int since = 0;
  logic [23:0] exp_p [4];
  logic [23:0] exp_f [4];

  phase_accumulator #(.SAMPLE_PERIOD(SP)) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .fcw_wr_en  (fcw_wr_en),
    .fcw_wr_addr(fcw_wr_addr),
    .fcw_wr_data(fcw_wr_data),
    .phase_clr  (phase_clr),
    .phase_1    (phase_1),
    .phase_2    (phase_2),
    .phase_3    (phase_3),
    .phase_4    (phase_4),
    .out_valid  (out_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
    $display("check %s observed=0x%0h expected=0x%0h", tag, obs, expv);
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic step();
    @(negedge clk);
    since++;
  endtask

  task automatic run_to(input int target);
    while (since < target) step();
  endtask

  task automatic wait_valid(input string tag, input int expected_gap);
    step();
    while (out_valid !== 1'b1 && since < 200) step();
    chk({tag, "_gap"}, 32'(since), 32'(expected_gap));
    since = 0;
  endtask

  // Expected phase advance on one sample; clr_mask selects voices that are cleared.
  task automatic advance(input logic [3:0] clr_mask);
    for (int i = 0; i < 4; i++) begin
      exp_p[i] = clr_mask[i] ? 24'h0 : exp_p[i] + exp_f[i];
    end
  endtask

  task automatic check_phases(input string tag);
    chk({tag, "_p1"}, 32'(phase_1), 32'(exp_p[0]));
    chk({tag, "_p2"}, 32'(phase_2), 32'(exp_p[1]));
    chk({tag, "_p3"}, 32'(phase_3), 32'(exp_p[2]));
    chk({tag, "_p4"}, 32'(phase_4), 32'(exp_p[3]));
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; fcw_wr_en = 1'b0; fcw_wr_addr = 2'd0;
    fcw_wr_data = 24'h0; phase_clr = 4'h0;
    for (int i = 0; i < 4; i++) begin exp_p[i] = 24'h0; exp_f[i] = 24'h0; end

    // Reset state
    step(); step();
    chk("rst_valid", 32'(out_valid), 32'h0);
    check_phases("rst");

    // Startup: pulses every 16 cycles, one cycle wide, phases stay zero
    rst = 1'b0; enable = 1'b1; since = 0;
    for (int k = 0; k < 3; k++) begin
      wait_valid("startup", 16);
      check_phases("startup");
    end

    // Accumulate and wrap
    fcw_wr_en = 1'b1; fcw_wr_addr = 2'd0; fcw_wr_data = 24'h100000; step();
    fcw_wr_addr = 2'd3; fcw_wr_data = 24'h000001; step();
    fcw_wr_en = 1'b0;
    exp_f[0] = 24'h100000; exp_f[3] = 24'h000001;
    for (int k = 1; k <= 16; k++) begin
      wait_valid("accum", 16);
      advance(4'h0);
      check_phases("accum");
    end
    chk("wrap_p1", 32'(phase_1), 32'h0);
    chk("wrap_p4", 32'(phase_4), 32'h10);

    // Write on the tick cycle takes effect one sample later
    fcw_wr_en = 1'b1; fcw_wr_addr = 2'd1; fcw_wr_data = 24'h10; step();
    fcw_wr_en = 1'b0;
    exp_f[1] = 24'h10;
    run_to(15);
    fcw_wr_en = 1'b1; fcw_wr_addr = 2'd1; fcw_wr_data = 24'h20;
    wait_valid("wrtick", 16);
    fcw_wr_en = 1'b0;
    advance(4'h0);
    exp_f[1] = 24'h20;
    check_phases("wrtick_a");
    chk("wrtick_p2_first", 32'(phase_2), 32'h10);
    wait_valid("wrtick", 16);
    advance(4'h0);
    check_phases("wrtick_b");
    chk("wrtick_p2_second", 32'(phase_2), 32'h30);

    // Phase clear: sticky request, then one coinciding with the tick
    fcw_wr_en = 1'b1; fcw_wr_addr = 2'd2; fcw_wr_data = 24'h400000; step();
    fcw_wr_en = 1'b0;
    exp_f[2] = 24'h400000;
    wait_valid("clr", 16);
    advance(4'h0);
    chk("clr_pre_p3", 32'(phase_3), 32'h400000);
    run_to(10);
    phase_clr = 4'b0100; step(); phase_clr = 4'h0;
    wait_valid("clr", 16);
    advance(4'b0100);
    check_phases("clr_sticky");
    chk("clr_sticky_p3", 32'(phase_3), 32'h0);
    wait_valid("clr", 16);
    advance(4'h0);
    chk("clr_after_p3", 32'(phase_3), 32'h400000);
    run_to(15);
    phase_clr = 4'b0100;
    wait_valid("clr", 16);
    phase_clr = 4'h0;
    advance(4'b0100);
    check_phases("clr_ontick");
    wait_valid("clr", 16);
    advance(4'h0);
    check_phases("clr_noresidue");

    // Enable gating: freeze with cnt=7 for 10 cycles
    run_to(7);
    enable = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      chk("gate_valid", 32'(out_valid), 32'h0);
    end
    enable = 1'b1;
    wait_valid("gate", 26);
    advance(4'h0);
    check_phases("gate");

    // Enable dropped on the tick cycle suppresses it until re-enable
    run_to(15);
    enable = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("tickgate_valid", 32'(out_valid), 32'h0);
    end
    enable = 1'b1;
    wait_valid("tickgate", 19);
    advance(4'h0);
    check_phases("tickgate");

    // Mid-operation reset with a pending clear on voice 1
    run_to(3);
    phase_clr = 4'b0001; step(); phase_clr = 4'h0;
    step();
    rst = 1'b1; step(); rst = 1'b0;
    for (int i = 0; i < 4; i++) begin exp_p[i] = 24'h0; exp_f[i] = 24'h0; end
    chk("mrst_valid", 32'(out_valid), 32'h0);
    check_phases("mrst");
    since = 0;
    fcw_wr_en = 1'b1; fcw_wr_addr = 2'd0; fcw_wr_data = 24'h000100; step();
    fcw_wr_en = 1'b0;
    exp_f[0] = 24'h000100;
    wait_valid("mrst", 16);
    advance(4'h0);
    check_phases("mrst_tick");
    chk("mrst_p1", 32'(phase_1), 32'h100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
